// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor
// Computes DIFF = A - B - BIN four bits per clock, least-significant block
// first, chaining a registered borrow between blocks so a single 4-bit slice
// does all the arithmetic. START is accepted in IDLE or FIN. BUSY is high for
// the N RUN cycles, and DONE pulses for one cycle in FIN. DIFF/BOUT/OVF are
// written only on the completing edge and hold until the next completion.
//
// Handshake: START is a request sampled on a rising CLK edge. It is taken only
// when STATE_DBG shows IDLE or FIN and is ignored while BUSY is high. There is
// no queueing. DONE marks the first cycle in which the new results are valid.
module block_serial_subtractor #(
    parameter int size = 32
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            START,
    input  logic [size-1:0] A,
    input  logic [size-1:0] B,
    input  logic            BIN,
    output logic [size-1:0] DIFF,
    output logic            BOUT,
    output logic            OVF,
    output logic            BUSY,
    output logic            DONE,
    output logic [1:0]      STATE_DBG
);

    localparam int N  = size / 4;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [size-1:0] a_q, a_d;
    logic [size-1:0] b_q, b_d;
    logic [size-1:0] work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic [size-1:0] diff_q, diff_d;
    logic            bout_q, bout_d;
    logic            ovf_q, ovf_d;

    // Bit offset of the block selected by the counter.
    logic [CW+1:0]   base;
    logic [3:0]      a_blk;
    logic [3:0]      b_blk;
    logic [4:0]      sum;

    // The slice adds A_k + ~B_k + ~borrow; the carry out is the inverse of the next borrow.
    always_comb begin
        base  = {cnt_q, 2'b00};
        a_blk = a_q[base +: 4];
        b_blk = b_q[base +: 4];
        sum   = {1'b0, a_blk} + {1'b0, ~b_blk} + {4'b0000, ~borrow_q};
    end

    // Next-state logic: accept in IDLE/FIN, one block per RUN edge, publish results on the last block.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE, S_FIN: begin
                if (START) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = BIN;
                    cnt_d    = '0;
                    state_d  = S_RUN;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_RUN: begin
                work_d[base +: 4] = sum[3:0];
                borrow_d          = ~sum[4];
                if (cnt_q == LAST) begin
                    diff_d  = work_d;
                    bout_d  = ~sum[4];
                    ovf_d   = (a_q[size-1] ^ b_q[size-1]) & (work_d[size-1] ^ a_q[size-1]);
                    state_d = S_FIN;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation and clears everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            ovf_q    <= ovf_d;
        end
    end

    // Every output comes straight from a register or a decode of the state register.
    always_comb begin
        DIFF      = diff_q;
        BOUT      = bout_q;
        OVF       = ovf_q;
        BUSY      = (state_q == S_RUN);
        DONE      = (state_q == S_FIN);
        STATE_DBG = state_q;
    end

endmodule
